gf2_three_way_mul: RTL and testbench

Parametrised digit-serial binary-polynomial (GF(2)[x]) multiplier built on a three-way operand split. It is the successor to the fixed 571-bit free-running three-way block. Width and digit size are parameters, the inputs are captured under a start/done handshake, and it produces a single registered, correctly aligned product per request. It sits in the large-integer/ECC datapath wherever a carry-less N×N product is needed ahead of field reduction.

---
 rtl/gf2_three_way_mul.sv | 176 +++++++++++++++++
 tb/tb_gf2_three_way_mul.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_three_way_mul.sv
// gf2_three_way_mul
//
// Digit-serial carry-less (GF(2)[x]) N x N multiplier built on a three-way operand
// split. Each operand is cut into three S-bit segments (S = ceil(N/3)). The nine segment
// products are accumulated in five (2S-1)-bit accumulators, DIGIT multiplier bits per
// segment per cycle. After ceil(S/DIGIT) steps the accumulators are recombined at
// multiples of S into one registered 2N-bit product.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset; has priority over start
//   start  request, accepted only while idle; a and b are captured on the accepting edge
//   a, b   N-bit operand polynomials, bit i = coefficient of x^i
//   busy   high from the accepting edge until the edge that raises done
//   done   one-cycle pulse; c is updated on the same edge
//   c      2N-bit product, held until the next done
module gf2_three_way_mul #(
  parameter int unsigned N     = 571,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int unsigned S       = (N + 2) / 3;
  localparam int unsigned AW      = 2 * S - 1;
  localparam int unsigned ACC_CYC = (S + DIGIT - 1) / DIGIT;
  localparam int unsigned CW      = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  // One spare bit above 6S keeps the never-populated top slice non-empty for every N.
  localparam int unsigned RW      = 6 * S + 1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StComb
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   c_q, c_d;

  // a segments shift right so bit k is always coefficient (step*DIGIT + k); b segments
  // shift left in step so their copy is already aligned to that coefficient.
  logic [S-1:0]     a_sh_q [3];
  logic [S-1:0]     a_sh_d [3];
  logic [AW-1:0]    b_sh_q [3];
  logic [AW-1:0]    b_sh_d [3];

  // acc[0] = h (a0b0) ... acc[4] = d (a2b2); index is the sum of segment indices.
  logic [AW-1:0]    acc_q [5];
  logic [AW-1:0]    acc_d [5];
  logic [AW-1:0]    acc_step [5];

  logic [3*S-1:0]   a_ext, b_ext;
  logic [RW-1:0]    comb;
  logic             unused_comb_hi;

  // Zero-extend operands to three full segments.
  always_comb begin
    a_ext        = '0;
    b_ext        = '0;
    a_ext[N-1:0] = a;
    b_ext[N-1:0] = b;
  end

  // One digit step. Coefficients at or beyond S have already shifted out of a_sh as
  // zeros, so a final partial digit adds nothing spurious. Bits of b_sh lost off the top
  // only ever pair with those zero coefficients.
  always_comb begin
    acc_step = acc_q;
    for (int k = 0; k < int'(DIGIT); k++) begin
      for (int i = 0; i < 3; i++) begin
        if (a_sh_q[i][k]) begin
          for (int m = 0; m < 3; m++) begin
            acc_step[i+m] = acc_step[i+m] ^ (b_sh_q[m] << k);
          end
        end
      end
    end
  end

  // Recombination: h ^ g<<S ^ f<<2S ^ e<<3S ^ d<<4S.
  always_comb begin
    comb = '0;
    for (int p = 0; p < 5; p++) begin
      comb[p*S +: AW] = comb[p*S +: AW] ^ acc_q[p];
    end
  end

  // A product of two degree < N polynomials never reaches bit 2N-1 or above.
  assign unused_comb_hi = ^comb[RW-1:2*N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    c_d     = c_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < 3; i++) begin
            a_sh_d[i] = a_ext[i*S +: S];
            b_sh_d[i] = {{(AW-S){1'b0}}, b_ext[i*S +: S]};
          end
          for (int p = 0; p < 5; p++) begin
            acc_d[p] = '0;
          end
          cnt_d   = '0;
          state_d = StAcc;
        end
      end

      StAcc: begin
        acc_d = acc_step;
        for (int i = 0; i < 3; i++) begin
          a_sh_d[i] = a_sh_q[i] >> DIGIT;
          b_sh_d[i] = b_sh_q[i] << DIGIT;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_CYC - 1)) begin
          state_d = StComb;
        end
      end

      StComb: begin
        c_d     = comb[2*N-1:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      c_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        a_sh_q[i] <= '0;
        b_sh_q[i] <= '0;
      end
      for (int p = 0; p < 5; p++) begin
        acc_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      c_q     <= c_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_gf2_three_way_mul.sv
// Self-checking bench for gf2_three_way_mul. Four instances with different N/DIGIT share
// one stimulus stream; each instance has its own scoreboard queue, filled when it accepts
// a request and drained when it raises done.
module tb_gf2_three_way_mul;

  localparam int ND = 4;
  localparam int NN  [ND] = '{571, 571, 7, 163};
  localparam int LAT [ND] = '{192, 49, 2, 2};  // ceil(S/DIGIT) + 1

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [570:0] a, b;

  logic          busy1, busy4, busy7, busy163;
  logic          done1, done4, done7, done163;
  logic [1141:0] c1, c4;
  logic [13:0]   c7;
  logic [325:0]  c163;

  logic          busy_v [ND];
  logic          done_v [ND];
  logic [1141:0] c_v    [ND];

  always #5 clk = ~clk;

  gf2_three_way_mul #(.N(571), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .c(c1)
  );
  gf2_three_way_mul #(.N(571), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy4), .done(done4), .c(c4)
  );
  gf2_three_way_mul #(.N(7), .DIGIT(3)) u_n7 (
    .clk(clk), .rst(rst), .start(start), .a(a[6:0]), .b(b[6:0]),
    .busy(busy7), .done(done7), .c(c7)
  );
  gf2_three_way_mul #(.N(163), .DIGIT(55)) u_n163 (
    .clk(clk), .rst(rst), .start(start), .a(a[162:0]), .b(b[162:0]),
    .busy(busy163), .done(done163), .c(c163)
  );

  always_comb begin
    busy_v[0] = busy1;  busy_v[1] = busy4;  busy_v[2] = busy7;  busy_v[3] = busy163;
    done_v[0] = done1;  done_v[1] = done4;  done_v[2] = done7;  done_v[3] = done163;
    c_v[0] = c1;
    c_v[1] = c4;
    c_v[2] = '0;
    c_v[2][13:0] = c7;
    c_v[3] = '0;
    c_v[3][325:0] = c163;
  end

  int checks = 0;
  int fails  = 0;

  logic [1141:0] sb_q  [ND][$];
  logic          got   [ND];
  logic [1141:0] exp_c [ND];

  // Results of the last run_req call.
  int            r_lat     [ND];
  int            r_ndone   [ND];
  int            r_sbbad   [ND];
  int            r_busybad;
  logic [1141:0] r_first_c [ND];
  logic [1141:0] r_bad_got [ND];
  logic [1141:0] r_bad_exp [ND];

  // Bit-level carry-less product of the low n bits of x and y.
  function automatic logic [1141:0] clmul(input logic [570:0] x, input logic [570:0] y,
                                          input int n);
    logic [1141:0] r;
    logic [1141:0] ym;
    r  = '0;
    ym = '0;
    for (int j = 0; j < n; j++) ym[j] = y[j];
    for (int i = 0; i < n; i++) begin
      if (x[i]) r = r ^ (ym << i);
    end
    return r;
  endfunction

  function automatic logic [570:0] rnd571();
    logic [575:0] w;
    for (int i = 0; i < 18; i++) w[i*32 +: 32] = $urandom;
    return w[570:0];
  endfunction

  // Advance one cycle. Pushes the expected product for every instance that accepts on
  // this edge, then at the next falling edge pops an expectation for every done.
  task automatic step();
    for (int d = 0; d < ND; d++) begin
      if (start === 1'b1 && rst === 1'b0 && busy_v[d] === 1'b0)
        sb_q[d].push_back(clmul(a, b, NN[d]));
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      got[d] = (done_v[d] === 1'b1);
      if (got[d]) begin
        if (sb_q[d].size() > 0) exp_c[d] = sb_q[d].pop_front();
        else exp_c[d] = 'x;
      end
    end
  endtask

  // Issue one request and observe 260 cycles. With disturb, start is re-pulsed with
  // different operands while the wide instances are still busy.
  task automatic run_req(input logic [570:0] ta, input logic [570:0] tb, input bit disturb);
    bit d0done;
    for (int d = 0; d < ND; d++) begin
      r_lat[d] = -1; r_ndone[d] = 0; r_sbbad[d] = 0;
      r_first_c[d] = '0; r_bad_got[d] = '0; r_bad_exp[d] = '0;
    end
    r_busybad = 0;
    a = ta; b = tb; start = 1'b1;
    step();
    start = 1'b0;
    if (busy_v[0] !== 1'b1) r_busybad++;
    d0done = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      if (disturb && k == 10) begin
        start = 1'b1; a = ~ta; b = ~tb;
      end else if (disturb && k == 11) begin
        start = 1'b0;
      end
      step();
      for (int d = 0; d < ND; d++) begin
        if (got[d]) begin
          r_ndone[d]++;
          if (r_lat[d] == -1) begin
            r_lat[d] = k;
            r_first_c[d] = c_v[d];
          end
          if (c_v[d] !== exp_c[d]) begin
            r_sbbad[d]++;
            r_bad_got[d] = c_v[d];
            r_bad_exp[d] = exp_c[d];
          end
        end
      end
      if (!d0done) begin
        if (got[0]) begin
          d0done = 1'b1;
          if (busy_v[0] !== 1'b0) r_busybad++;
        end else if (busy_v[0] !== 1'b1) begin
          r_busybad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0) begin
        fails++; $display("FAIL reset dut%0d busy: got %b want 0", d, busy_v[d]);
      end
      checks++;
      if (done_v[d] !== 1'b0) begin
        fails++; $display("FAIL reset dut%0d done: got %b want 0", d, done_v[d]);
      end
      checks++;
      if (c_v[d] !== '0) begin
        fails++; $display("FAIL reset dut%0d c: got %h want 0", d, c_v[d][63:0]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [570:0] one;
    one = '0; one[0] = 1'b1;
    run_req(one, one, 1'b0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (r_ndone[d] !== 1) begin
        fails++; $display("FAIL single dut%0d done count: got %0d want 1", d, r_ndone[d]);
      end
      checks++;
      if (r_lat[d] !== LAT[d]) begin
        fails++; $display("FAIL single dut%0d latency: got %0d want %0d", d, r_lat[d], LAT[d]);
      end
      checks++;
      if (r_first_c[d] !== 1142'd1) begin
        fails++; $display("FAIL single dut%0d c: got %h want 1", d, r_first_c[d][63:0]);
      end
    end
    checks++;
    if (r_busybad !== 0) begin
      fails++; $display("FAIL single busy profile: %0d bad cycles, want 0", r_busybad);
    end
  endtask

  task automatic test_boundary();
    logic [570:0]  ta, tb;
    logic [1141:0] ev;
    for (int t = 0; t < 2; t++) begin
      ta = '0; tb = '0; ev = '0;
      if (t == 0) begin
        ta[570] = 1'b1; tb[570] = 1'b1; ev[1140] = 1'b1;
      end else begin
        ta[190] = 1'b1; tb[191] = 1'b1; ev[381] = 1'b1;
      end
      run_req(ta, tb, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (r_first_c[d] !== ev) begin
          fails++;
          $display("FAIL boundary%0d dut%0d c: got %h (hi %h) want bit set only",
                   t, d, r_first_c[d][63:0], r_first_c[d][1141:1078]);
        end
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (r_sbbad[d] !== 0 || r_ndone[d] !== 1) begin
          fails++;
          $display("FAIL boundary%0d dut%0d scoreboard: %0d bad of %0d dones, want 0 of 1",
                   t, d, r_sbbad[d], r_ndone[d]);
        end
      end
    end
  endtask

  task automatic test_square();
    logic [1141:0] ev;
    ev = '0;
    for (int i = 0; i <= 1140; i += 2) ev[i] = 1'b1;
    run_req({571{1'b1}}, {571{1'b1}}, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (r_first_c[d] !== ev) begin
        fails++;
        $display("FAIL square dut%0d c: got %h want %h (low 64)", d, r_first_c[d][63:0],
                 ev[63:0]);
      end
      checks++;
      if (r_lat[d] !== LAT[d]) begin
        fails++; $display("FAIL square dut%0d latency: got %0d want %0d", d, r_lat[d], LAT[d]);
      end
    end
    for (int d = 2; d < ND; d++) begin
      checks++;
      if (r_sbbad[d] !== 0 || r_ndone[d] !== 1) begin
        fails++;
        $display("FAIL square dut%0d scoreboard: %0d bad of %0d dones, want 0 of 1",
                 d, r_sbbad[d], r_ndone[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      run_req(rnd571(), rnd571(), 1'b0);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (r_sbbad[d] !== 0 || r_ndone[d] !== 1) begin
          fails++;
          $display("FAIL random%0d dut%0d product: got %h want %h (low 64), %0d dones",
                   t, d, r_bad_got[d][63:0], r_bad_exp[d][63:0], r_ndone[d]);
        end
        checks++;
        if (r_lat[d] !== LAT[d]) begin
          fails++;
          $display("FAIL random%0d dut%0d latency: got %0d want %0d", t, d, r_lat[d], LAT[d]);
        end
      end
    end
  endtask

  // Wide instances ignore the second pulse; narrow ones are idle again and take it.
  task automatic test_busy_start();
    int wantn;
    run_req(rnd571(), rnd571(), 1'b1);
    for (int d = 0; d < ND; d++) begin
      wantn = (d < 2) ? 1 : 2;
      checks++;
      if (r_ndone[d] !== wantn) begin
        fails++;
        $display("FAIL busy_start dut%0d done count: got %0d want %0d", d, r_ndone[d], wantn);
      end
      checks++;
      if (r_sbbad[d] !== 0) begin
        fails++;
        $display("FAIL busy_start dut%0d product: got %h want %h (low 64)",
                 d, r_bad_got[d][63:0], r_bad_exp[d][63:0]);
      end
    end
    checks++;
    if (r_busybad !== 0) begin
      fails++; $display("FAIL busy_start busy profile: %0d bad cycles, want 0", r_busybad);
    end
  endtask

  task automatic test_back_to_back();
    int last [ND];
    int nd0;
    for (int d = 0; d < ND; d++) last[d] = -1;
    nd0 = 0;
    start = 1'b1;
    for (int k = 0; k < 600; k++) begin
      a = rnd571(); b = rnd571();
      step();
      for (int d = 0; d < ND; d++) begin
        if (got[d]) begin
          checks++;
          if (c_v[d] !== exp_c[d]) begin
            fails++;
            $display("FAIL b2b dut%0d product: got %h want %h (low 64)", d, c_v[d][63:0],
                     exp_c[d][63:0]);
          end
          if (last[d] != -1) begin
            checks++;
            if (k - last[d] !== LAT[d] + 1) begin
              fails++;
              $display("FAIL b2b dut%0d period: got %0d want %0d", d, k - last[d], LAT[d] + 1);
            end
          end
          last[d] = k;
          if (d == 0) nd0++;
        end
      end
    end
    start = 1'b0;
    for (int k = 0; k < 250; k++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        if (got[d]) begin
          checks++;
          if (c_v[d] !== exp_c[d]) begin
            fails++;
            $display("FAIL b2b drain dut%0d product: got %h want %h (low 64)", d,
                     c_v[d][63:0], exp_c[d][63:0]);
          end
          if (d == 0) nd0++;
        end
      end
    end
    checks++;
    if (nd0 !== 4) begin
      fails++; $display("FAIL b2b dut0 total dones: got %0d want 4", nd0);
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (sb_q[d].size() !== 0) begin
        fails++;
        $display("FAIL b2b dut%0d pending: got %0d want 0", d, sb_q[d].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    a = rnd571(); b = rnd571(); start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 100; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0) begin
        fails++; $display("FAIL reset_mid dut%0d busy: got %b want 0", d, busy_v[d]);
      end
      checks++;
      if (done_v[d] !== 1'b0) begin
        fails++; $display("FAIL reset_mid dut%0d done: got %b want 0", d, done_v[d]);
      end
      checks++;
      if (c_v[d] !== '0) begin
        fails++; $display("FAIL reset_mid dut%0d c: got %h want 0", d, c_v[d][63:0]);
      end
    end
    for (int d = 0; d < ND; d++) sb_q[d].delete();
    ndone = 0;
    for (int k = 0; k < 250; k++) begin
      step();
      for (int d = 0; d < ND; d++) if (got[d]) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      fails++; $display("FAIL reset_mid stray dones: got %0d want 0", ndone);
    end
    run_req(rnd571(), rnd571(), 1'b0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (r_sbbad[d] !== 0 || r_ndone[d] !== 1 || r_lat[d] !== LAT[d]) begin
        fails++;
        $display("FAIL reset_mid rerun dut%0d: %0d bad, %0d dones, latency %0d want 0/1/%0d",
                 d, r_sbbad[d], r_ndone[d], r_lat[d], LAT[d]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_single();
    test_boundary();
    test_square();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
